conv_stream_engine: RTL
=======================

// Module: conv_stream_engine
// PURPOSE
//  Parametrised next-generation convolution engine. Loads C-channel KxK filters and NxN ifmaps over
//  valid/ready byte streams, computes a valid (no-pad) strided convolution summed over channels with one
//  sequential signed MAC, then streams scaled, saturated results out with backpressure and a last flag.
//  Sits between the host-side serial loaders and the result collector; replaces fixed-size 5x3 control.
// PARAMETERS
//  DATA_W   8   ifmap/filter element width, two's complement
//  IFMAP    5   ifmap side N
//  FILTER   3   filter side K (K <= N)
//  CHANNELS 1   input channels C, accumulated into one output map
//  STRIDE   1   convolution stride S; (N-K)%S!=0 is an elaboration error
//  ACC_W    24  accumulator width; >= 2*DATA_W+clog2(C*K*K)
//  OUT_W    8   output element width
//  SHIFT    0   arithmetic right shift applied to accumulator before saturation
//  Derived: OUT=(N-K)/S+1, M=C*K*K MACs per output pixel
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       synchronous, active-high reset
//  start      in   1       begin a job; sampled only in IDLE
//  busy       out  1       high in every state except IDLE
//  done       out  1       one-cycle pulse after last output beat accepted
//  sat_flag   out  1       sticky: any output saturated since last start
//  flt_data   in   DATA_W  filter element; order channel, row, column
//  flt_valid  in   1       filter beat valid
//  flt_ready  out  1       high only in LOAD_FLT
//  ifm_data   in   DATA_W  ifmap element; order channel, row, column
//  ifm_valid  in   1       ifmap beat valid
//  ifm_ready  out  1       high only in LOAD_IFM
//  out_data   out  OUT_W   result pixel, row-major
//  out_valid  out  1       result valid; held with data stable until out_ready
//  out_ready  in   1       downstream accept
//  out_last   out  1       high with final pixel (index OUT*OUT-1)
// BEHAVIOUR
//  Reset: state IDLE; busy, done, sat_flag, flt_ready, ifm_ready, out_valid, out_last = 0; out_data = 0;
//   counters/accumulator = 0. Buffer contents not cleared. Reset mid-job aborts it, no done.
//  FSM: IDLE -start-> LOAD_FLT (sat_flag cleared) -M-th flt beat-> LOAD_IFM -(C*N*N)-th ifm beat-> COMPUTE
//   -last pixel loaded into output reg-> DRAIN -last beat accepted-> DONE (done=1, one cycle) -> IDLE.
//  Beat accepted only when valid&&ready on the same edge; valid gaps allowed, counters hold.
//  start while busy ignored. Beats on a stream whose ready is low are ignored.
//  COMPUTE: per pixel (oy,ox), iterate c,ky,kx; acc += ifm[c][oy*S+ky][ox*S+kx]*flt[c][ky][kx], one MAC/cycle,
//   full-precision signed product sign-extended to ACC_W; acc restarts from first product of each pixel.
//  Finalize (cycle after M-th MAC): v = acc >>> SHIFT; clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1];
//   set sat_flag if clamped; load out_data, set out_valid, out_last if final pixel.
//  Latency: pixel 0 out_valid high M+1 edges after edge accepting last ifm beat (out_ready held high).
//  Throughput: one pixel per M+1 cycles when not backpressured.
//  Output reg one deep: if out_valid && !out_ready at finalize, MAC pipeline stalls (acc, counters hold)
//   until accept; no pixel dropped or duplicated. out_valid drops on accept unless new pixel loaded same edge.
//  Simultaneous accept and finalize on same edge: new pixel replaces accepted one, out_valid stays 1.
//  Counters wrap to 0 at end of each dimension; pixel counter end triggers DRAIN.
// TESTING
//  1 C=1,S=1, flt centre=1 else 0, ifm=0..24 -> out 6,7,8,11,12,13,16,17,18; out_last on 9th; done pulse; sat_flag=0.
//  2 flt all 1, ifm all 1, out_ready random 50% -> nine 9s in order, data stable while stalled, no loss/dup.
//  3 flt all 127, ifm all 127 -> nine 127, sat_flag=1; flt all 127, ifm all -128 -> nine -128, sat_flag=1.
//  4 S=2,N=5,K=3 -> 4 outputs; C=2, both channels all 1 -> four 18s; SHIFT=1 -> four 9s.
//  5 valid gaps on flt/ifm streams, start pulsed during LOAD_IFM -> ignored, results identical to test 1.
//  6 rst asserted mid-COMPUTE -> next edge all outputs at reset values; new start then job of test 1 passes.

Source files
------------

// File: rtl/conv_stream_engine.sv
// Streaming convolution engine: loads C-channel KxK filters and NxN ifmaps over byte streams,
// computes a valid strided convolution summed over channels with one sequential signed MAC, and
// streams shifted, saturated results out through a one-deep output register with backpressure.
module conv_stream_engine #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned IFMAP    = 5,
    parameter int unsigned FILTER   = 3,
    parameter int unsigned CHANNELS = 1,
    parameter int unsigned STRIDE   = 1,
    parameter int unsigned ACC_W    = 24,
    parameter int unsigned OUT_W    = 8,
    parameter int unsigned SHIFT    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              sat_flag_o,
    input  logic [DATA_W-1:0] flt_data_i,
    input  logic              flt_valid_i,
    output logic              flt_ready_o,
    input  logic [DATA_W-1:0] ifm_data_i,
    input  logic              ifm_valid_i,
    output logic              ifm_ready_o,
    output logic [OUT_W-1:0]  out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              out_last_o
);

    localparam int unsigned OutDim = (IFMAP - FILTER) / STRIDE + 1;
    localparam int unsigned MacN   = CHANNELS * FILTER * FILTER;
    localparam int unsigned IfmN   = CHANNELS * IFMAP * IFMAP;
    localparam int unsigned LdW    = $clog2(IfmN + 1);
    localparam int unsigned DimW   = $clog2(IFMAP + 1);
    localparam int unsigned ChW    = $clog2(CHANNELS + 1);
    localparam int unsigned FIdxW  = (MacN > 1) ? $clog2(MacN) : 1;
    localparam int unsigned IIdxW  = (IfmN > 1) ? $clog2(IfmN) : 1;
    localparam int unsigned ProdW  = 2 * DATA_W;

    localparam int OutMaxI = (1 << (OUT_W - 1)) - 1;
    localparam logic signed [ACC_W-1:0] OutMax = ACC_W'(OutMaxI);
    localparam logic signed [ACC_W-1:0] OutMin = ACC_W'(-OutMaxI - 1);

    // Geometry must tile exactly and the accumulator must hold a full product.
    if (FILTER > IFMAP || ((IFMAP - FILTER) % STRIDE) != 0 || ACC_W < ProdW) begin : g_bad_cfg
        $error("conv_stream_engine: illegal geometry or accumulator width");
    end

    typedef enum logic [2:0] {
        StIdle,
        StLoadFlt,
        StLoadIfm,
        StCompute,
        StDrain,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [DATA_W-1:0] flt_mem [MacN];
    logic [DATA_W-1:0] ifm_mem [IfmN];

    logic [LdW-1:0]          ld_q, ld_d;
    logic [ChW-1:0]          c_q, c_d;
    logic [DimW-1:0]         ky_q, ky_d, kx_q, kx_d, oy_q, oy_d, ox_q, ox_d;
    logic                    fin_q, fin_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    sat_q, sat_d;
    logic [OUT_W-1:0]        out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_last_q, out_last_d;

    logic                    flt_beat, ifm_beat;
    logic [FIdxW-1:0]        flt_idx;
    logic [IIdxW-1:0]        ifm_idx;
    logic signed [ProdW-1:0] flt_ext, ifm_ext, prod;
    logic signed [ACC_W-1:0] prod_ext, shifted;
    logic [OUT_W-1:0]        sat_val;
    logic                    clamped, first_term, last_pix;

    assign flt_beat = (state_q == StLoadFlt) && flt_valid_i;
    assign ifm_beat = (state_q == StLoadIfm) && ifm_valid_i;

    // Buffer writes; contents survive reset by design.
    always_ff @(posedge clk) begin
        if (!rst && flt_beat) flt_mem[FIdxW'(ld_q)] <= flt_data_i;
        if (!rst && ifm_beat) ifm_mem[IIdxW'(ld_q)] <= ifm_data_i;
    end

    // Operand addressing and sign-extended full-precision product.
    always_comb begin
        flt_idx    = FIdxW'((int'(c_q) * FILTER + int'(ky_q)) * FILTER + int'(kx_q));
        ifm_idx    = IIdxW'((int'(c_q) * IFMAP + int'(oy_q) * STRIDE + int'(ky_q)) * IFMAP
                            + int'(ox_q) * STRIDE + int'(kx_q));
        flt_ext    = ProdW'($signed(flt_mem[flt_idx]));
        ifm_ext    = ProdW'($signed(ifm_mem[ifm_idx]));
        prod       = flt_ext * ifm_ext;
        prod_ext   = ACC_W'(prod);
        first_term = (c_q == '0) && (ky_q == '0) && (kx_q == '0);
        last_pix   = (ox_q == DimW'(OutDim - 1)) && (oy_q == DimW'(OutDim - 1));
    end

    // Scale and saturate the finished accumulator.
    always_comb begin
        shifted = acc_q >>> SHIFT;
        clamped = 1'b1;
        if (shifted > OutMax) begin
            sat_val = OUT_W'(OutMax);
        end else if (shifted < OutMin) begin
            sat_val = OUT_W'(OutMin);
        end else begin
            clamped = 1'b0;
            sat_val = OUT_W'(shifted);
        end
    end

    // Next-state: FSM, load/MAC/pixel counters and the one-deep output register.
    always_comb begin
        state_d     = state_q;
        ld_d        = ld_q;
        c_d         = c_q;
        ky_d        = ky_q;
        kx_d        = kx_q;
        oy_d        = oy_q;
        ox_d        = ox_q;
        fin_d       = fin_q;
        acc_d       = acc_q;
        sat_d       = sat_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StLoadFlt;
                    sat_d   = 1'b0;
                end
            end
            StLoadFlt: begin
                if (flt_beat) begin
                    if (ld_q == LdW'(MacN - 1)) begin
                        ld_d    = '0;
                        state_d = StLoadIfm;
                    end else begin
                        ld_d = ld_q + LdW'(1);
                    end
                end
            end
            StLoadIfm: begin
                if (ifm_beat) begin
                    if (ld_q == LdW'(IfmN - 1)) begin
                        ld_d    = '0;
                        state_d = StCompute;
                    end else begin
                        ld_d = ld_q + LdW'(1);
                    end
                end
            end
            StCompute: begin
                if (!fin_q) begin
                    acc_d = first_term ? prod_ext : acc_q + prod_ext;
                    if (kx_q == DimW'(FILTER - 1)) begin
                        kx_d = '0;
                        if (ky_q == DimW'(FILTER - 1)) begin
                            ky_d = '0;
                            if (c_q == ChW'(CHANNELS - 1)) begin
                                c_d   = '0;
                                fin_d = 1'b1;
                            end else begin
                                c_d = c_q + ChW'(1);
                            end
                        end else begin
                            ky_d = ky_q + DimW'(1);
                        end
                    end else begin
                        kx_d = kx_q + DimW'(1);
                    end
                end else if (!out_valid_q || out_ready_i) begin
                    // Finalize; an occupied, unaccepted output register stalls here instead.
                    fin_d       = 1'b0;
                    out_data_d  = sat_val;
                    out_valid_d = 1'b1;
                    out_last_d  = last_pix;
                    if (clamped) sat_d = 1'b1;
                    if (ox_q == DimW'(OutDim - 1)) begin
                        ox_d = '0;
                        if (oy_q == DimW'(OutDim - 1)) begin
                            oy_d    = '0;
                            state_d = StDrain;
                        end else begin
                            oy_d = oy_q + DimW'(1);
                        end
                    end else begin
                        ox_d = ox_q + DimW'(1);
                    end
                end
            end
            StDrain: begin
                if (out_valid_q && out_ready_i) state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            ld_q        <= '0;
            c_q         <= '0;
            ky_q        <= '0;
            kx_q        <= '0;
            oy_q        <= '0;
            ox_q        <= '0;
            fin_q       <= 1'b0;
            acc_q       <= '0;
            sat_q       <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ld_q        <= ld_d;
            c_q         <= c_d;
            ky_q        <= ky_d;
            kx_q        <= kx_d;
            oy_q        <= oy_d;
            ox_q        <= ox_d;
            fin_q       <= fin_d;
            acc_q       <= acc_d;
            sat_q       <= sat_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign busy_o      = (state_q != StIdle);
    assign done_o      = (state_q == StDone);
    assign flt_ready_o = (state_q == StLoadFlt);
    assign ifm_ready_o = (state_q == StLoadIfm);
    assign sat_flag_o  = sat_q;
    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;
    assign out_last_o  = out_last_q;

endmodule
